// File: rtl/rom_burst_reader_if.sv
// Bundles the command, ROM-side and stream-side signals of the burst reader.
// The reader drives the master modport; the ROM and consumer sit on the slave side.
interface rom_burst_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    input  start, start_addr, length, mem_data, out_ready,
    output busy, done, mem_en, mem_addr, out_data, out_valid, out_last
  );

  modport slave (
    output start, start_addr, length, mem_data, out_ready,
    input  busy, done, mem_en, mem_addr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/rom_burst_reader.sv
// Burst read initiator for a synchronous single-port ROM with one-cycle latency.
// Reads are only issued when the 2-entry output FIFO is guaranteed to have room for the result.
module rom_burst_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst_n,
  rom_burst_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] rd_addr, last_addr;
  logic [ADDR_W:0]   len_q, issue_cnt, push_cnt;
  logic              inflight;
  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic              rd_ptr, wr_ptr;
  logic [1:0]        occ;
  logic [2:0]        credit;
  logic              issue, push, pop;

  assign pop    = bus.out_valid & bus.out_ready;
  assign push   = inflight;
  // Words already owned (buffered or on their way) minus the one leaving this cycle.
  assign credit = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign issue  = (state == READ) && (issue_cnt != len_q) && (credit < 3'd2);

  assign bus.mem_en    = issue;
  assign bus.mem_addr  = issue ? rd_addr : last_addr;
  assign bus.busy      = (state == READ) || (state == DRAIN);
  assign bus.done      = (state == DONE);
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = fifo_data[rd_ptr];
  assign bus.out_last  = fifo_last[rd_ptr] & bus.out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) state_next = (bus.length == '0) ? DONE : READ;
      end
      READ: begin
        if (issue && (issue_cnt + CNT_ONE == len_q)) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && bus.out_last) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address/count bookkeeping plus the FIFO that absorbs the ROM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr   <= '0;
      last_addr <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      push_cnt  <= '0;
      inflight  <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
      fifo_last <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      occ       <= 2'd0;
    end else begin
      inflight <= issue;
      if (state == IDLE && bus.start && bus.length != '0) begin
        rd_addr   <= bus.start_addr;
        len_q     <= bus.length;
        issue_cnt <= '0;
        push_cnt  <= '0;
      end
      if (issue) begin
        last_addr <= rd_addr;
        rd_addr   <= rd_addr + ADDR_ONE;
        issue_cnt <= issue_cnt + CNT_ONE;
      end
      if (push) begin
        fifo_data[wr_ptr] <= bus.mem_data;
        fifo_last[wr_ptr] <= (push_cnt == len_q - CNT_ONE);
        wr_ptr            <= ~wr_ptr;
        push_cnt          <= push_cnt + CNT_ONE;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader: table of bursts, reset and busy-start corner cases,
// then random bursts under random backpressure against a queue-based stream model.
module tb_rom_burst_reader;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } word_t;

  typedef struct {
    logic [3:0] addr;
    logic [4:0] len;
    bit         rdy_rand;
    int         spam_at;
    int         exp_first_cyc;
    int         exp_done_cyc;
    int         exp_first_data;
    int         exp_last_data;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  rom_burst_reader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  rom_burst_reader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ROM contents: location a holds {a,a}; output is 0 whenever the ROM is disabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          bus.mem_data <= 8'h00;
    else if (bus.mem_en) bus.mem_data <= {bus.mem_addr, bus.mem_addr};
    else                 bus.mem_data <= 8'h00;
  end

  int pass_n  = 0;
  int total_n = 0;

  word_t      exp_q[$];
  logic [3:0] addr_q[$];
  int         issued_n = 0;
  int         popped_n = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_n++;
    if (actual == expected) pass_n++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Stream monitor: every read and every handshake is matched against the expected queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", bus.out_valid, 1);
        checkOutput("stall_data", bus.out_data, prev_data);
        checkOutput("stall_last", bus.out_last, prev_last);
      end
      if (bus.mem_en) begin
        checkOutput("read_expected", int'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) checkOutput("mem_addr", bus.mem_addr, addr_q.pop_front());
        checkOutput("outstanding_le2",
                    int'((issued_n + 1) - (popped_n + int'(bus.out_valid & bus.out_ready)) <= 2), 1);
        issued_n++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checkOutput("word_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          checkOutput("out_data", bus.out_data, exp_q[0].data);
          checkOutput("out_last", bus.out_last, exp_q[0].last);
          void'(exp_q.pop_front());
        end
        popped_n++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  // One burst starting the cycle after the call; cycle 0 is the cycle start is held high.
  task automatic applyStimulus(input logic [3:0] a, input logic [4:0] n, input bit rdy_rand,
                               input int spam_at, output int first_cyc, output int done_cyc,
                               output int first_data, output int last_data);
    bit saw_busy = 0;
    first_cyc  = -1;
    done_cyc   = -1;
    first_data = -1;
    last_data  = -1;
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back('{data: 8'(((int'(a) + i) % 16) * 17), last: (i == int'(n) - 1)});
      addr_q.push_back(4'((int'(a) + i) % 16));
    end
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.length     = n;
    bus.out_ready  = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        bus.start = (c == spam_at);
        if (c == spam_at) begin
          bus.start_addr = ~a;
          bus.length     = 5'd3;
        end
        bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clk);
      if (c == 1) checkOutput("busy_cycle1", bus.busy, int'(n != 0));
      if (bus.busy) saw_busy = 1;
      if (bus.out_valid && first_cyc < 0) first_cyc = c;
      if (bus.out_valid && bus.out_ready) begin
        if (first_data < 0) first_data = bus.out_data;
        last_data = bus.out_data;
      end
      if (bus.done) begin
        done_cyc = c;
        break;
      end
    end
    checkOutput("done_seen", int'(done_cyc >= 0), 1);
    if (done_cyc >= 0) checkOutput("busy_at_done", bus.busy, 0);
    checkOutput("words_left", exp_q.size(), 0);
    checkOutput("reads_left", addr_q.size(), 0);
    if (n == 0) checkOutput("len0_busy", saw_busy, 0);
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_done"}, bus.done, 0);
    checkOutput({tag, "_mem_en"}, bus.mem_en, 0);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr, 0);
    checkOutput({tag, "_out_data"}, bus.out_data, 0);
    checkOutput({tag, "_out_valid"}, bus.out_valid, 0);
    checkOutput({tag, "_out_last"}, bus.out_last, 0);
  endtask

  task automatic clearModel();
    exp_q.delete();
    addr_q.delete();
    issued_n = 0;
    popped_n = 0;
  endtask

  vec_t vecs[7];

  initial begin
    int fc, dc, fd, ld, base, guard;

    vecs[0] = '{4'd2,  5'd4,  1'b0, -1, 3,  7, 8'h22, 8'h55};
    vecs[1] = '{4'd14, 5'd4,  1'b0, -1, 3,  7, 8'hEE, 8'h11};
    vecs[2] = '{4'd0,  5'd16, 1'b1, -1, 3, -1, 8'h00, 8'hFF};
    vecs[3] = '{4'd7,  5'd0,  1'b0,  1, -1, 1, -1,    -1};
    vecs[4] = '{4'd9,  5'd3,  1'b0,  2, 3,  6, 8'h99, 8'hBB};
    vecs[5] = '{4'd15, 5'd1,  1'b0, -1, 3,  4, 8'hFF, 8'hFF};
    vecs[6] = '{4'd0,  5'd16, 1'b0, -1, 3, 19, 8'h00, 8'hFF};

    bus.start      = 1'b0;
    bus.start_addr = 4'd0;
    bus.length     = 5'd0;
    bus.out_ready  = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkResetOutputs("por");
    @(negedge clk); #1 rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].addr, vecs[v].len, vecs[v].rdy_rand, vecs[v].spam_at, fc, dc, fd, ld);
      checkOutput($sformatf("v%0d_first_cycle", v), fc, vecs[v].exp_first_cyc);
      if (vecs[v].exp_done_cyc >= 0) checkOutput($sformatf("v%0d_done_cycle", v), dc, vecs[v].exp_done_cyc);
      checkOutput($sformatf("v%0d_first_data", v), fd, vecs[v].exp_first_data);
      checkOutput($sformatf("v%0d_last_data", v), ld, vecs[v].exp_last_data);
    end

    // Reset after two words of a 10-word burst; outputs must clear without waiting for a clock.
    base = popped_n;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back('{data: 8'(i * 17), last: (i == 9)});
      addr_q.push_back(4'(i));
    end
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.start_addr = 4'd0;
    bus.length     = 5'd10;
    @(posedge clk); #1 bus.start = 1'b0;
    guard = 0;
    while (popped_n < base + 2 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("rst_two_words", popped_n - base, 2);
    #1 rst_n = 1'b0;
    #1 checkResetOutputs("midrst");
    clearModel();
    @(negedge clk); #1 rst_n = 1'b1;
    applyStimulus(4'd5, 5'd2, 1'b0, -1, fc, dc, fd, ld);
    checkOutput("after_rst_first_cycle", fc, 3);
    checkOutput("after_rst_done_cycle", dc, 5);
    checkOutput("after_rst_first_data", fd, 8'h55);
    checkOutput("after_rst_last_data", ld, 8'h66);

    for (int r = 0; r < 15; r++) begin
      logic [3:0] ra;
      logic [4:0] rn;
      ra = 4'($urandom_range(0, 15));
      rn = 5'($urandom_range(0, 16));
      applyStimulus(ra, rn, 1'b1, -1, fc, dc, fd, ld);
      if (rn != 0) checkOutput($sformatf("rand%0d_first_cycle", r), fc, 3);
      else         checkOutput($sformatf("rand%0d_done_cycle", r), dc, 1);
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Read initiator for the 16 x 8 synchronous single-port ROM. One `start` command reads `length` consecutive ROM locations from `start_addr`, wrapping modulo 16. The block drives the ROM's `en`/`addr` pins, absorbs the ROM's one-cycle read latency, and streams the words out on a valid/ready interface with full backpressure support. It sits between the ROM and any consumer that cannot accept data every cycle.

## Interface
Parameters:
- `ADDR_W`, 4, ROM address width; depth is 2^ADDR_W.
- `DATA_W`, 8, ROM data width.

Ports:
- `clk`  in  1  system clock, posedge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `start`  in  1  command strobe; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first address of the burst.
- `length`  in  ADDR_W+1  word count, 0..16.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse at burst end.
- `mem_en`  out  1  ROM enable; one read per high cycle.
- `mem_addr`  out  ADDR_W  ROM address.
- `mem_data`  in  DATA_W  ROM data; valid the cycle after `mem_en` is high.
- `out_data`  out  DATA_W  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  consumer ready.
- `out_last`  out  1  marks the final word of the burst, qualified by `out_valid`.

## Operation
State machine:
- IDLE → READ on `start` with `length` != 0. `start_addr` and `length` are latched on that edge.
- IDLE → DONE on `start` with `length` == 0. No ROM access is made.
- READ → DRAIN once `length` reads have been issued.
- DRAIN → DONE on the handshake (`out_valid & out_ready`) of the word with `out_last`.
- DONE → IDLE unconditionally. DONE lasts one cycle.

Read issue and buffering:
- A read is issued in READ when `occ + inflight - pop < 2`.
  - `occ` is the number of words held in a 2-entry output FIFO.
  - `inflight` is 1 if `mem_en` was high in the previous cycle.
  - `pop` is the output handshake in the current cycle.
- This guarantees the FIFO never overflows. No ROM word is ever dropped or read twice.
- The address counter increments after each issued read and wraps from 15 to 0.
- `mem_en` is 0 whenever no read is issued. `mem_addr` holds its last value when idle.
- `mem_data` is pushed into the FIFO only in the cycle after `mem_en` was 1. The ROM outputs 0 while disabled, so it must never be sampled otherwise.
- `out_data`, `out_valid` and `out_last` are driven from the FIFO head.
  - `out_data` and `out_last` stay stable while `out_valid` is high and `out_ready` is low.
  - `out_last` is asserted on the word whose index equals `length - 1`.

Control and boundary rules:
- `busy` is 1 in READ and DRAIN.
- `done` is 1 only in DONE.
- `start` is ignored outside IDLE.
- `rst_n` low at any time takes effect immediately:
  - state returns to IDLE;
  - the FIFO and counters are cleared;
  - an in-flight read is discarded.

Reset values: `busy`=0, `done`=0, `mem_en`=0, `mem_addr`=0, `out_data`=0, `out_valid`=0, `out_last`=0.

## Timing
- Cycle 0: `start` is sampled high in IDLE.
- Cycle 1: `busy`=1; first `mem_en`=1 with `mem_addr`=`start_addr`.
- Cycle 2: `mem_data` is valid and pushed into the FIFO.
- Cycle 3: first `out_valid`=1. Start-to-first-data latency is 3 cycles.
- With `out_ready` held high, throughput is 1 word/cycle with no bubbles.
- An N-word burst with constant ready has its last handshake in cycle N+2, `done` in cycle N+3, and `busy`=0 in cycle N+3.
- With `length`=0: `done`=1 in cycle 1; `busy` stays 0.
- At most one ROM read is outstanding at a time.

## Test plan
- `start_addr`=2, `length`=4, `out_ready`=1 → stream 0x22, 0x33, 0x44, 0x55 in cycles 3–6; `out_last` high on 0x55 only; `done` in cycle 7.
- Wrap: `start_addr`=14, `length`=4 → 0xEE, 0xFF, 0x00, 0x11; `mem_addr` sequence 14, 15, 0, 1.
- Backpressure: `start_addr`=0, `length`=16, `out_ready` toggling pseudo-randomly → exactly 0x00..0xFF in order, with no duplicates or drops. Outputs stay stable while stalled. FIFO occupancy plus in-flight reads never exceeds 2.
- `length`=0 → no `mem_en` pulses; `done` pulses in cycle 1; `busy` stays 0. A second `start` pulsed while `busy`=1 has no effect on the stream.
- Reset mid-burst: assert `rst_n`=0 after 2 words of a 10-word burst → all outputs go to 0 immediately. A new burst (`start_addr`=5, `length`=2) then yields 0x55, 0x66 only.
- Back-to-back commands: a `start` in the cycle after `done` → the new burst begins normally with the same 3-cycle latency.
